// File: rtl/data_bus_driver_if.sv
// Shared (a, b, c) data bus: one driver, any number of read-only users.
interface data_bus_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;

  modport driver (output a, output b, output c);
  modport user   (input  a, input  b, input  c);
endinterface

// File: rtl/data_bus_driver.sv
// Assembles a serial word stream into (a, b, c) triples and commits each
// complete triple to the data bus in a single cycle.
module data_bus_driver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  input  logic                 flush,
  data_bus_if.driver           bus,
  output logic                 bus_update,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] triple_count
);

  typedef enum logic [1:0] {
    S_A = 2'd0,
    S_B = 2'd1,
    S_C = 2'd2
  } state_t;

  state_t               state_q,  state_d;
  logic [WIDTH-1:0]     sh_a_q,   sh_a_d;
  logic [WIDTH-1:0]     sh_b_q,   sh_b_d;
  logic [WIDTH-1:0]     bus_a_q,  bus_a_d;
  logic [WIDTH-1:0]     bus_b_q,  bus_b_d;
  logic [WIDTH-1:0]     bus_c_q,  bus_c_d;
  logic                 update_q, update_d;
  logic                 busy_q,   busy_d;
  logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
  logic                 xfer;

  // Ready depends only on flush, never on in_valid.
  assign in_ready = !flush;
  assign xfer     = in_valid && in_ready;

  // Next-state: collect words a, b, then commit on c; flush abandons a partial triple.
  always_comb begin
    state_d  = state_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    bus_a_d  = bus_a_q;
    bus_b_d  = bus_b_q;
    bus_c_d  = bus_c_q;
    update_d = 1'b0;
    cnt_d    = cnt_q;
    if (flush) begin
      state_d = S_A;
    end else if (xfer) begin
      unique case (state_q)
        S_A: begin
          sh_a_d  = in_data;
          state_d = S_B;
        end
        S_B: begin
          sh_b_d  = in_data;
          state_d = S_C;
        end
        S_C: begin
          bus_a_d  = sh_a_q;
          bus_b_d  = sh_b_q;
          bus_c_d  = in_data;
          update_d = 1'b1;
          cnt_d    = cnt_q + CNT_WIDTH'(1);
          state_d  = S_A;
        end
        default: state_d = S_A;
      endcase
    end
    busy_d = (state_d != S_A);
  end

  // State and output registers; reset wins over any same-edge commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_A;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      bus_a_q  <= '0;
      bus_b_q  <= '0;
      bus_c_q  <= '0;
      update_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      bus_a_q  <= bus_a_d;
      bus_b_q  <= bus_b_d;
      bus_c_q  <= bus_c_d;
      update_q <= update_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.a        = bus_a_q;
  assign bus.b        = bus_b_q;
  assign bus.c        = bus_c_q;
  assign bus_update   = update_q;
  assign busy         = busy_q;
  assign triple_count = cnt_q;

endmodule

// File: tb/tb_data_bus_driver.sv
// Self-checking bench for data_bus_driver (WIDTH=16, CNT_WIDTH=2 to reach counter wrap quickly).
module tb_data_bus_driver;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          flush;
  logic          bus_update;
  logic          busy;
  logic [CW-1:0] triple_count;

  data_bus_if #(.WIDTH(W)) bus_i ();

  data_bus_driver #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .flush        (flush),
    .bus          (bus_i),
    .bus_update   (bus_update),
    .busy         (busy),
    .triple_count (triple_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: words collected so far plus the last committed view.
  logic [W-1:0]  part[$];
  logic [W-1:0]  m_a, m_b, m_c;
  logic          m_upd;
  int            m_cnt;

  // Apply one clock edge to both the model and the DUT, then settle.
  task automatic cycle();
    m_upd = 1'b0;
    if (rst) begin
      part.delete();
      m_a = '0; m_b = '0; m_c = '0;
      m_cnt = 0;
    end else if (flush) begin
      part.delete();
    end else if (in_valid) begin
      part.push_back(in_data);
      if (part.size() == 3) begin
        m_a = part[0]; m_b = part[1]; m_c = part[2];
        part.delete();
        m_upd = 1'b1;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic f);
    in_valid = v;
    in_data  = d;
    flush    = f;
  endtask

  task automatic send(input logic [W-1:0] d);
    drive(1'b1, d, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if ({bus_i.a, bus_i.b, bus_i.c} !== '0) begin
        errors++; $display("FAIL reset_bus got %h/%h/%h exp 0", bus_i.a, bus_i.b, bus_i.c);
      end
      checks++;
      if ({bus_update, busy, in_ready} !== 3'b001) begin
        errors++; $display("FAIL reset_flags upd/busy/rdy got %b%b%b exp 001", bus_update, busy, in_ready);
      end
      checks++;
      if (triple_count !== 2'd0) begin
        errors++; $display("FAIL reset_count got %0d exp 0", triple_count);
      end
    end
  endtask

  task automatic test_basic();
    send(16'h00F0);
    send(16'h003C);
    drive(1'b1, 16'h00FF, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0);
    checks++;
    if ({bus_i.a, bus_i.b, bus_i.c} !== {16'h00F0, 16'h003C, 16'h00FF}) begin
      errors++; $display("FAIL basic_bus got %h/%h/%h exp 00f0/003c/00ff", bus_i.a, bus_i.b, bus_i.c);
    end
    checks++;
    if (bus_update !== 1'b1 || triple_count !== 2'd1) begin
      errors++; $display("FAIL basic_commit upd=%b cnt=%0d exp upd=1 cnt=1", bus_update, triple_count);
    end
    checks++;
    if ((bus_i.a & bus_i.b & bus_i.c) !== 16'h0030) begin
      errors++; $display("FAIL basic_and got %h exp 0030", bus_i.a & bus_i.b & bus_i.c);
    end
    cycle();
    checks++;
    if (bus_update !== 1'b0) begin
      errors++; $display("FAIL basic_pulse_len got %b exp 0", bus_update);
    end
  endtask

  task automatic test_gaps();
    send(16'h0011);
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (busy !== 1'b1 || bus_i.a !== 16'h00F0 || bus_update !== 1'b0) begin
        errors++; $display("FAIL gaps_hold1 busy=%b a=%h upd=%b exp busy=1 a=00f0 upd=0", busy, bus_i.a, bus_update);
      end
    end
    send(16'h0022);
    idle(2);
    checks++;
    if (busy !== 1'b1 || bus_i.c !== 16'h00FF) begin
      errors++; $display("FAIL gaps_hold2 busy=%b c=%h exp busy=1 c=00ff", busy, bus_i.c);
    end
    send(16'h0033);
    checks++;
    if ({bus_i.a, bus_i.b, bus_i.c} !== {16'h0011, 16'h0022, 16'h0033} || busy !== 1'b0) begin
      errors++; $display("FAIL gaps_bus got %h/%h/%h busy=%b exp 0011/0022/0033 busy=0", bus_i.a, bus_i.b, bus_i.c, busy);
    end
  endtask

  task automatic test_flush();
    send(16'h00AA);
    send(16'h00BB);
    drive(1'b1, 16'h00CC, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got %b exp 0", in_ready);
    end
    cycle();
    checks++;
    if (busy !== 1'b0 || bus_update !== 1'b0 || {bus_i.a, bus_i.b, bus_i.c} !== {16'h0011, 16'h0022, 16'h0033}) begin
      errors++; $display("FAIL flush_state busy=%b upd=%b bus=%h/%h/%h exp busy=0 upd=0 0011/0022/0033",
                         busy, bus_update, bus_i.a, bus_i.b, bus_i.c);
    end
    send(16'h00CC);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL flush_fresh_a busy got %b exp 1", busy);
    end
    send(16'h00DD);
    send(16'h00EE);
    checks++;
    if ({bus_i.a, bus_i.b, bus_i.c} !== {16'h00CC, 16'h00DD, 16'h00EE} || triple_count !== 2'd3) begin
      errors++; $display("FAIL flush_after bus=%h/%h/%h cnt=%0d exp 00cc/00dd/00ee cnt=3",
                         bus_i.a, bus_i.b, bus_i.c, triple_count);
    end
  endtask

  task automatic test_wrap();
    logic [CW-1:0] exp_seq [5];
    int pulses;
    int k;
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0; exp_seq[4] = 2'd1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    pulses = 0;
    k = 0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, W'($urandom), 1'b0);
      cycle();
      if (bus_update === 1'b1) pulses++;
      if (i % 3 == 2) begin
        checks++;
        if (triple_count !== exp_seq[k]) begin
          errors++; $display("FAIL wrap_count[%0d] got %0d exp %0d", k, triple_count, exp_seq[k]);
        end
        k++;
      end
    end
    drive(1'b0, '0, 1'b0);
    cycle();
    if (bus_update === 1'b1) pulses++;
    checks++;
    if (pulses != 5) begin
      errors++; $display("FAIL wrap_pulses got %0d exp 5", pulses);
    end
  endtask

  task automatic test_reset_mid();
    send(16'h1234);
    send(16'h5678);
    drive(1'b1, 16'h9ABC, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    checks++;
    if ({bus_i.a, bus_i.b, bus_i.c} !== '0 || triple_count !== 2'd0 || bus_update !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_state bus=%h/%h/%h cnt=%0d upd=%b busy=%b exp all 0",
                         bus_i.a, bus_i.b, bus_i.c, triple_count, bus_update, busy);
    end
    send(16'h000F);
    send(16'h00FF);
    send(16'h0FFF);
    checks++;
    if ({bus_i.a, bus_i.b, bus_i.c} !== {16'h000F, 16'h00FF, 16'h0FFF} || triple_count !== 2'd1) begin
      errors++; $display("FAIL rstmid_after bus=%h/%h/%h cnt=%0d exp 000f/00ff/0fff cnt=1",
                         bus_i.a, bus_i.b, bus_i.c, triple_count);
    end
  endtask

  task automatic test_random();
    logic [CW-1:0] exp_cnt;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 7) == 0));
      #1;
      checks++;
      if (in_ready !== !flush) begin
        errors++; $display("FAIL rand_ready[%0d] got %b exp %b", i, in_ready, !flush);
      end
      cycle();
      exp_cnt = CW'(m_cnt);
      checks++;
      if ({bus_i.a, bus_i.b, bus_i.c} !== {m_a, m_b, m_c}) begin
        errors++; $display("FAIL rand_bus[%0d] got %h/%h/%h exp %h/%h/%h", i, bus_i.a, bus_i.b, bus_i.c, m_a, m_b, m_c);
      end
      checks++;
      if (bus_update !== m_upd || busy !== (part.size() != 0) || triple_count !== exp_cnt) begin
        errors++; $display("FAIL rand_ctl[%0d] upd=%b busy=%b cnt=%0d exp upd=%b busy=%b cnt=%0d",
                           i, bus_update, busy, triple_count, m_upd, part.size() != 0, exp_cnt);
      end
    end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_a = '0; m_b = '0; m_c = '0; m_upd = 1'b0; m_cnt = 0;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    test_reset();
    test_basic();
    test_gaps();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
